kmeans_result_collector: RTL and testbench

KMEANS_RESULT_COLLECTOR -- requirements
Module: kmeans_result_collector

---
 rtl/kmeans_result_collector_pkg.sv | 20 ++
 rtl/kmeans_accum_bank.sv | 50 +++++
 rtl/kmeans_result_collector.sv | 152 +++++++++++++++
 tb/tb_kmeans_result_collector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_result_collector_pkg.sv
// rtl/kmeans_result_collector_pkg.sv - shared types and constants for the k-means result collector
package kmeans_result_collector_pkg;

  localparam int COUNT_W = 32;
  localparam int COORD_W = 64;

  typedef enum logic [1:0] {
    ST_CENT  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width-independent part of a result beat; sums are carried alongside at SUM_W.
  typedef struct packed {
    logic [15:0]        index;
    logic [COUNT_W-1:0] count;
    logic               last;
  } result_rec_t;

endpackage

// File: rtl/kmeans_accum_bank.sv
// rtl/kmeans_accum_bank.sv - per-cluster count and coordinate-sum storage, one write and one read port
module kmeans_accum_bank
  import kmeans_result_collector_pkg::*;
#(
  parameter int NUM_CLUSTERS = 16,
  parameter int SUM_W        = 80,
  parameter int AW           = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [COUNT_W-1:0] wr_count,
  input  logic [SUM_W-1:0]   wr_sum_x,
  input  logic [SUM_W-1:0]   wr_sum_y,
  input  logic [SUM_W-1:0]   wr_sum_z,
  input  logic [AW-1:0]      rd_addr,
  output logic [COUNT_W-1:0] rd_count,
  output logic [SUM_W-1:0]   rd_sum_x,
  output logic [SUM_W-1:0]   rd_sum_y,
  output logic [SUM_W-1:0]   rd_sum_z
);

  logic [COUNT_W-1:0] count_mem [NUM_CLUSTERS];
  logic [SUM_W-1:0]   sum_x_mem [NUM_CLUSTERS];
  logic [SUM_W-1:0]   sum_y_mem [NUM_CLUSTERS];
  logic [SUM_W-1:0]   sum_z_mem [NUM_CLUSTERS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        count_mem[i] <= '0;
        sum_x_mem[i] <= '0;
        sum_y_mem[i] <= '0;
        sum_z_mem[i] <= '0;
      end
    end else if (wr_en) begin
      count_mem[wr_addr] <= wr_count;
      sum_x_mem[wr_addr] <= wr_sum_x;
      sum_y_mem[wr_addr] <= wr_sum_y;
      sum_z_mem[wr_addr] <= wr_sum_z;
    end
  end

  assign rd_count = count_mem[rd_addr];
  assign rd_sum_x = sum_x_mem[rd_addr];
  assign rd_sum_y = sum_y_mem[rd_addr];
  assign rd_sum_z = sum_z_mem[rd_addr];

endmodule

// File: rtl/kmeans_result_collector.sv
// rtl/kmeans_result_collector.sv - accumulates per-cluster point sums and drains them as result beats
module kmeans_result_collector
  import kmeans_result_collector_pkg::*;
#(
  parameter int NUM_CLUSTERS = 16,
  parameter int SUM_W        = 80
) (
  input  logic               clk,
  input  logic               reset,
  output logic               io_in_ready,
  input  logic               io_in_valid,
  input  logic               io_in_bits_centeroidsFinished,
  input  logic               io_in_bits_pointsFinished,
  input  logic [15:0]        io_in_bits_centeroidIndex,
  input  logic [COORD_W-1:0] io_in_bits_point_x,
  input  logic [COORD_W-1:0] io_in_bits_point_y,
  input  logic [COORD_W-1:0] io_in_bits_point_z,
  input  logic               io_out_ready,
  output logic               io_out_valid,
  output logic [15:0]        io_out_bits_index,
  output logic [COUNT_W-1:0] io_out_bits_count,
  output logic [SUM_W-1:0]   io_out_bits_sum_x,
  output logic [SUM_W-1:0]   io_out_bits_sum_y,
  output logic [SUM_W-1:0]   io_out_bits_sum_z,
  output logic               io_out_bits_last,
  output logic [15:0]        err_count
);

  localparam int AW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(NUM_CLUSTERS - 1);

  state_t        state;
  logic [AW-1:0] ptr;

  logic               in_fire, out_fire, idx_ok, acc_fire;
  logic               wr_en;
  logic [AW-1:0]      wr_addr, rd_addr;
  logic [COUNT_W-1:0] wr_count, rd_count;
  logic [SUM_W-1:0]   wr_sum_x, wr_sum_y, wr_sum_z;
  logic [SUM_W-1:0]   rd_sum_x, rd_sum_y, rd_sum_z;
  result_rec_t        res;

  assign in_fire  = io_in_valid && io_in_ready;
  assign out_fire = io_out_valid && io_out_ready;
  assign idx_ok   = io_in_bits_centeroidIndex < 16'(NUM_CLUSTERS);
  assign acc_fire = in_fire && (state == ST_ACCUM) && !io_in_bits_pointsFinished && idx_ok;

  // The single read port serves the read-modify-write while accumulating and the drain otherwise.
  assign rd_addr = (state == ST_DRAIN) ? ptr : io_in_bits_centeroidIndex[AW-1:0];

  always_comb begin
    wr_en    = acc_fire || out_fire;
    wr_addr  = out_fire ? ptr : io_in_bits_centeroidIndex[AW-1:0];
    wr_count = '0;
    wr_sum_x = '0;
    wr_sum_y = '0;
    wr_sum_z = '0;
    if (acc_fire) begin
      wr_count = (rd_count == '1) ? rd_count : rd_count + 1'b1;
      wr_sum_x = rd_sum_x + SUM_W'($signed(io_in_bits_point_x));
      wr_sum_y = rd_sum_y + SUM_W'($signed(io_in_bits_point_y));
      wr_sum_z = rd_sum_z + SUM_W'($signed(io_in_bits_point_z));
    end
  end

  kmeans_accum_bank #(
    .NUM_CLUSTERS(NUM_CLUSTERS),
    .SUM_W       (SUM_W),
    .AW          (AW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_count(wr_count),
    .wr_sum_x(wr_sum_x),
    .wr_sum_y(wr_sum_y),
    .wr_sum_z(wr_sum_z),
    .rd_addr (rd_addr),
    .rd_count(rd_count),
    .rd_sum_x(rd_sum_x),
    .rd_sum_y(rd_sum_y),
    .rd_sum_z(rd_sum_z)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_CENT;
      ptr          <= '0;
      io_in_ready  <= 1'b0;
      io_out_valid <= 1'b0;
      err_count    <= '0;
    end else begin
      case (state)
        ST_CENT: begin
          io_in_ready <= 1'b1;
          if (in_fire && io_in_bits_centeroidsFinished) begin
            if (io_in_bits_pointsFinished) begin
              state        <= ST_DRAIN;
              io_in_ready  <= 1'b0;
              io_out_valid <= 1'b1;
              ptr          <= '0;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (in_fire) begin
            if (io_in_bits_pointsFinished) begin
              state        <= ST_DRAIN;
              io_in_ready  <= 1'b0;
              io_out_valid <= 1'b1;
              ptr          <= '0;
            end else if (!idx_ok && err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (ptr == LAST_PTR) begin
              state        <= ST_CENT;
              io_out_valid <= 1'b0;
              io_in_ready  <= 1'b1;
              ptr          <= '0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= ST_CENT;
      endcase
    end
  end

  always_comb begin
    res       = '0;
    res.index = 16'(ptr);
    res.count = rd_count;
    res.last  = (ptr == LAST_PTR);
    if (!io_out_valid) res = '0;
  end

  assign io_out_bits_index = res.index;
  assign io_out_bits_count = res.count;
  assign io_out_bits_last  = res.last;
  assign io_out_bits_sum_x = io_out_valid ? rd_sum_x : '0;
  assign io_out_bits_sum_y = io_out_valid ? rd_sum_y : '0;
  assign io_out_bits_sum_z = io_out_valid ? rd_sum_z : '0;

endmodule

// File: tb/tb_kmeans_result_collector.sv
// tb/tb_kmeans_result_collector.sv - randomized self-checking bench for kmeans_result_collector
module tb_kmeans_result_collector;

  localparam int N  = 4;
  localparam int SW = 80;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_ready, in_valid = 1'b0, cf = 1'b0, pf = 1'b0;
  logic [15:0]   in_idx = '0;
  logic [63:0]   px = '0, py = '0, pz = '0;
  logic          out_ready = 1'b0, out_valid, out_last;
  logic [15:0]   out_index, err_count;
  logic [31:0]   out_count;
  logic [SW-1:0] out_sx, out_sy, out_sz;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = centroid, 1 = points, 2 = draining.
  int            phase;
  int            m_err;
  longint        m_cnt [N];
  logic [SW-1:0] m_sx [N], m_sy [N], m_sz [N];

  kmeans_result_collector #(.NUM_CLUSTERS(N), .SUM_W(SW)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .io_in_ready                  (in_ready),
    .io_in_valid                  (in_valid),
    .io_in_bits_centeroidsFinished(cf),
    .io_in_bits_pointsFinished    (pf),
    .io_in_bits_centeroidIndex    (in_idx),
    .io_in_bits_point_x           (px),
    .io_in_bits_point_y           (py),
    .io_in_bits_point_z           (pz),
    .io_out_ready                 (out_ready),
    .io_out_valid                 (out_valid),
    .io_out_bits_index            (out_index),
    .io_out_bits_count            (out_count),
    .io_out_bits_sum_x            (out_sx),
    .io_out_bits_sum_y            (out_sy),
    .io_out_bits_sum_z            (out_sz),
    .io_out_bits_last             (out_last),
    .err_count                    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] sext(input logic [63:0] v);
    logic signed [SW-1:0] s;
    s = $signed(v);
    return s;
  endfunction

  task automatic model_reset();
    phase = 0;
    m_err = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_sx[i] = '0; m_sy[i] = '0; m_sz[i] = '0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic c, input logic p, input int idx,
                      input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
    int n = 0;
    in_valid = 1'b1; cf = c; pf = p; in_idx = 16'(idx); px = x; py = y; pz = z;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0; cf = 1'b0; pf = 1'b0;
    if (phase == 0) begin
      if (c && p) phase = 2;
      else if (c) phase = 1;
    end else if (phase == 1) begin
      if (p) phase = 2;
      else if (idx >= N) begin
        if (m_err < 16'hFFFF) m_err++;
      end else begin
        if (m_cnt[idx] < 64'hFFFF_FFFF) m_cnt[idx]++;
        m_sx[idx] += sext(x); m_sy[idx] += sext(y); m_sz[idx] += sext(z);
      end
    end
  endtask

  task automatic send_marker_pf();
    send(1'b0, 1'b1, 0, '0, '0, '0);
    check("drain_latency_valid", out_valid, 1);
    check("drain_in_ready", in_ready, 0);
    check("err_count", err_count, 16'(m_err));
  endtask

  // bp_beat < 0 selects random backpressure on every beat.
  task automatic drain(input int nbeats, input int bp_beat, input int bp_len);
    for (int k = 0; k < nbeats; k++) begin
      int n = 0;
      int hold;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("out_valid", out_valid, 1);
      check("out_index", out_index, 16'(k));
      check("out_count", out_count, 32'(m_cnt[k]));
      check("out_sum_x", out_sx, m_sx[k]);
      check("out_sum_y", out_sy, m_sy[k]);
      check("out_sum_z", out_sz, m_sz[k]);
      check("out_last", out_last, (k == N - 1));
      hold = (bp_beat < 0) ? int'($urandom_range(0, 2)) : ((k == bp_beat) ? bp_len : 0);
      out_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check("bp_valid", out_valid, 1);
        check("bp_index", out_index, 16'(k));
        check("bp_count", out_count, 32'(m_cnt[k]));
        check("bp_sum_x", out_sx, m_sx[k]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      m_cnt[k] = 0; m_sx[k] = '0; m_sy[k] = '0; m_sz[k] = '0;
    end
  endtask

  task automatic drain_full(input int bp_beat, input int bp_len);
    drain(N, bp_beat, bp_len);
    phase = 0;
    check("post_drain_valid", out_valid, 0);
    check("post_drain_in_ready", in_ready, 1);
  endtask

  task automatic random_points(input int npts);
    for (int i = 0; i < npts; i++)
      send(1'b0, 1'b0, $urandom_range(0, N + 1), {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  initial begin
    model_reset();
    // Reset behaviour
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_count", err_count, 0);
    check("rst_out_count", out_count, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // Basic frame with backpressure mid-drain
    for (int i = 0; i < 10; i++)
      send(1'b0, 1'b0, $urandom_range(0, N - 1), {$urandom, $urandom}, {$urandom, $urandom}, '0);
    send(1'b1, 1'b0, 0, 64'd99, 64'd99, 64'd99);
    send(1'b0, 1'b0, 1, 64'd1, 64'd2, 64'd3);
    send(1'b0, 1'b0, 1, -64'sd5, 64'd0, 64'd7);
    send_marker_pf();
    check("basic_count1", out_count, 0);
    drain_full(1, 5);

    // Out-of-range index
    send(1'b1, 1'b0, 0, '0, '0, '0);
    send(1'b0, 1'b0, 2, 64'd10, -64'sd10, 64'd4);
    send(1'b0, 1'b0, 7, 64'd1000, 64'd1000, 64'd1000);
    check("oor_err_count", err_count, 1);
    send_marker_pf();
    drain_full(-1, 0);

    // Both markers in centroid phase
    send(1'b1, 1'b1, 0, 64'd5, 64'd5, 64'd5);
    check("both_valid", out_valid, 1);
    drain_full(-1, 0);

    // Random frames; centroidsFinished during points must be ignored
    for (int f = 0; f < 3; f++) begin
      random_points(3);
      send(1'b1, 1'b0, 0, '0, '0, '0);
      random_points(12);
      send(1'b1, 1'b0, 1, 64'd3, 64'd3, 64'd3);
      random_points(6);
      send_marker_pf();
      drain_full(-1, 0);
    end

    // Reset in the middle of a drain at pointer 2
    send(1'b1, 1'b0, 0, '0, '0, '0);
    random_points(8);
    send_marker_pf();
    drain(2, -1, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_err", err_count, 0);
    model_reset();
    @(negedge clk);
    check("mid_rst_hold_valid", out_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", in_ready, 1);
    check("mid_rel_valid", out_valid, 0);

    // Accumulators start clean after the abandoned drain
    send(1'b1, 1'b0, 0, '0, '0, '0);
    send(1'b0, 1'b0, 3, 64'd7, 64'd8, 64'd9);
    send_marker_pf();
    drain_full(-1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=0", 1);
    $fatal(1, "timeout");
  end

endmodule
